// File: rtl/fifo_buffer.sv
// Single-clock FIFO of WIDTH-bit words with a normal (consuming) mode and a
// circular mode in which every accepted read re-appends the head word (or the
// incoming word, if a write coincides) at the tail so the contents replay.
module fifo_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             circular,
  input  logic [WIDTH-1:0] datain,
  input  logic             write,
  input  logic             read,
  output logic [WIDTH-1:0] dataout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic             rd_ok;
  logic             wr_ok;
  logic             recirc;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic             cnt_inc;
  logic [AW:0]      count_nxt;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Accept decisions and the single storage write port, all from pre-edge state.
  // A write is still accepted when full if a word leaves on the same edge.
  // In circular mode a read with no write writes the head word back at the
  // tail; when full the tail slot is the slot just read, which is safe
  // because the read data is taken from the pre-edge contents.
  always_comb begin
    rd_ok     = read & ~empty;
    wr_ok     = write & (~full | rd_ok);
    recirc    = circular & rd_ok;
    mem_we    = wr_ok | recirc;
    mem_wdata = wr_ok ? datain : mem[rd_ptr];
    cnt_inc   = wr_ok | recirc;
    count_nxt = count + (AW+1)'(cnt_inc) - (AW+1)'(rd_ok);
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= mem_wdata;
    end
  end

  // Pointers, occupancy and registered read data; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      dataout <= '0;
    end else begin
      if (rd_ok) begin
        dataout <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (mem_we) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed bench for fifo_buffer: reset, empty read+write, fill/overflow,
// circular replay and replace, full circular replay, reset mid-operation.
module tb_fifo_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             reset;
  logic             circular;
  logic [WIDTH-1:0] datain;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] dataout;
  logic             full;
  logic             empty;
  logic [AW:0]      count;

  int checks;
  int failures;

  fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .circular(circular),
    .datain  (datain),
    .write   (write),
    .read    (read),
    .dataout (dataout),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] rep [3];
  logic [WIDTH-1:0] rpl [3];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    circular = 1'b0;
    datain   = '0;
    write    = 1'b0;
    read     = 1'b0;

    // Reset / idle
    step();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_dataout", 64'(dataout), 64'd0);
    reset = 1'b0;
    read  = 1'b1;
    step();
    check("idle_read_dataout", 64'(dataout), 64'd0);
    check("idle_read_count", 64'(count), 64'd0);

    // Read+write on empty: write only, no bypass
    write  = 1'b1;
    datain = 32'h9;
    step();
    check("erw1_count", 64'(count), 64'd1);
    check("erw1_dataout", 64'(dataout), 64'd0);
    datain = 32'h1;
    step();
    check("erw2_dataout", 64'(dataout), 64'h9);
    check("erw2_count", 64'(count), 64'd1);
    write = 1'b0;
    step();
    check("erw3_dataout", 64'(dataout), 64'h1);
    check("erw3_empty", 64'(empty), 64'd1);
    step();
    check("erw4_hold", 64'(dataout), 64'h1);
    check("erw4_count", 64'(count), 64'd0);

    // Fill with DEPTH+1 words; the last is dropped
    read  = 1'b0;
    write = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      datain = WIDTH'(i);
      step();
      if (i == DEPTH - 2) check("fill_not_full", 64'(full), 64'd0);
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_count", 64'(count), 64'(DEPTH));
    write = 1'b0;
    read  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check("drain_data", 64'(dataout), 64'(i));
    end
    check("drain_empty", 64'(empty), 64'd1);
    step();
    check("drain_extra_hold", 64'(dataout), 64'(DEPTH - 1));

    // Circular replay of three words
    read  = 1'b0;
    write = 1'b1;
    rep[0] = 32'hA;
    rep[1] = 32'hE;
    rep[2] = 32'h47F;
    for (int i = 0; i < 3; i++) begin
      datain = rep[i];
      step();
    end
    check("circ_load_count", 64'(count), 64'd3);
    write    = 1'b0;
    circular = 1'b1;
    read     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("circ_replay_data", 64'(dataout), 64'(rep[i % 3]));
      check("circ_replay_count", 64'(count), 64'd3);
      check("circ_replay_empty", 64'(empty), 64'd0);
    end

    // Circular replace: head 0xA leaves, 0x0 enters at the tail
    write  = 1'b1;
    datain = 32'h0;
    step();
    check("circ_replace_out", 64'(dataout), 64'hA);
    check("circ_replace_count", 64'(count), 64'd3);
    write  = 1'b0;
    rpl[0] = 32'hE;
    rpl[1] = 32'h47F;
    rpl[2] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("circ_after_replace", 64'(dataout), 64'(rpl[i % 3]));
      check("circ_after_count", 64'(count), 64'd3);
    end

    // Reset mid-operation with circular reads active
    reset = 1'b1;
    step();
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_dataout", 64'(dataout), 64'd0);
    reset    = 1'b0;
    read     = 1'b0;
    circular = 1'b0;
    write    = 1'b1;
    datain   = 32'h5;
    step();
    write = 1'b0;
    read  = 1'b1;
    step();
    check("midrst_readback", 64'(dataout), 64'h5);
    check("midrst_after_count", 64'(count), 64'd0);

    // Circular replay while full: recirculating write lands on the slot just read
    read  = 1'b0;
    write = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      datain = 32'h100 + WIDTH'(i);
      step();
    end
    check("cfull_full", 64'(full), 64'd1);
    write    = 1'b0;
    circular = 1'b1;
    read     = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      step();
      check("cfull_data", 64'(dataout), 64'(32'h100 + (i % DEPTH)));
      check("cfull_count", 64'(count), 64'(DEPTH));
    end

    // Full, circular, read+write: head replaced by new word at tail
    write  = 1'b1;
    datain = 32'hBEEF;
    step();
    check("cfull_replace_out", 64'(dataout), 64'h104);
    check("cfull_replace_full", 64'(full), 64'd1);
    write = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if (i == DEPTH - 1) check("cfull_replaced_word", 64'(dataout), 64'hBEEF);
      else check("cfull_other_words", 64'(dataout), 64'(32'h105 + ((i) % DEPTH) - ((i >= 11) ? DEPTH : 0)));
    end

    // Normal mode, full, read+write: both accepted, count unchanged
    circular = 1'b0;
    write    = 1'b1;
    datain   = 32'h77;
    step();
    check("nfull_rw_count", 64'(count), 64'(DEPTH));
    check("nfull_rw_out", 64'(dataout), 64'h105);

    write = 1'b0;
    read  = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Synchronous single-clock FIFO buffer of 32-bit words with a normal (consuming) mode and a circular (recirculating) mode, selected by the `circular` input.
- In circular mode, each read returns the head word and re-appends it at the tail, so the stored contents replay endlessly.
- Sits between a producer and a consumer; the handshake signals are flattened from the team's FIFO link bundle: `datain`, `write`, `read`, `dataout`, `full`, `empty`.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of storage entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- circular  input  1  1 = circular (recirculating) mode; 0 = normal mode.
- datain  input  WIDTH  write data.
- write  input  1  write request.
- read  input  1  read request.
- dataout  output  WIDTH  registered read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  number of stored words.

Behaviour:
- Reset (sampled on a clk edge while reset=1):
  - read pointer, write pointer and count all go to 0.
  - dataout=0, empty=1, full=0; storage contents are don't-care.
  - Reset has priority over every other input, including mid-operation.
- Accept conditions, evaluated on pre-edge state:
  - wr_ok = write & ~full.
  - rd_ok = read & ~empty.
  - Requests that are not accepted are silently ignored; there is no error flag.
- Read latency is one cycle:
  - On an edge with rd_ok, dataout takes mem[rd_ptr].
  - dataout holds its value whenever no read is accepted.
- There is no write-to-read bypass:
  - Read and write on an empty FIFO perform the write only; the word is readable the next cycle.
- Normal mode (circular=0):
  - wr_ok: mem[wr_ptr] <= datain; wr_ptr++ (wraps mod DEPTH).
  - rd_ok: rd_ptr++ (wraps mod DEPTH).
  - count += wr_ok - rd_ok.
  - Read and write together when full: both are accepted (write is allowed because a word is leaving), and count is unchanged. This is the one exception to wr_ok; define wr_ok = write & (~full | rd_ok).
- Circular mode (circular=1):
  - rd_ok without write: dataout <= mem[rd_ptr]; mem[wr_ptr] <= mem[rd_ptr]; both pointers advance; count unchanged. The word is recirculated.
  - rd_ok with write: dataout <= mem[rd_ptr]; mem[wr_ptr] <= datain; both pointers advance; count unchanged. The head word is replaced by the new word at the tail.
  - write without rd_ok: same as normal-mode write; ignored if full.
  - When full, rd_ptr == wr_ptr, so the recirculating write targets the slot just read. This is legal and must preserve data.
- Mode changes:
  - circular may change on any cycle; it takes effect the same edge.
  - Pointers and contents are unaffected by a mode switch.
- Flags full, empty and count are derived from registered count and are valid in the cycle after each edge.

Test Plan:
- Reset/idle:
  - Stimulus: hold reset 1 cycle, then release.
  - Response: empty=1, full=0, count=0, dataout=0; a read on the empty FIFO leaves dataout=0 and count=0.
- Empty read+write:
  - Stimulus: read=write=1 with datain=0x9, then datain=0x1, then write=0 with read=1.
  - Response: cycle 1 writes 0x9 only (count=1); cycle 2 dataout=0x9, count stays 1; cycle 3 dataout=0x1, empty=1. Further reads hold dataout=0x1.
- Fill and overflow:
  - Stimulus: write 0..DEPTH (DEPTH+1 words) with no reads.
  - Response: full=1 after DEPTH writes; the last word is dropped. Reading back returns 0..DEPTH-1 in order, then empty=1.
- Circular replay:
  - Stimulus: write 0xA, 0xE, 0x47F; set circular=1, read=1 for 12 cycles.
  - Response: dataout sequence 0xA, 0xE, 0x47F repeated 4 times; count stays 3; empty never asserts.
- Circular replace:
  - Stimulus: continuing the previous scenario, one cycle with read=write=1 and datain=0x0, then reads only.
  - Response: that cycle outputs the current head word. The subsequent sequence contains 0x0 in place of that word and the other two words unchanged; count stays 3.
- Reset mid-operation:
  - Stimulus: with 3 words stored and circular=1, assert reset while read=1.
  - Response: after the edge, count=0, empty=1, dataout=0; a write of 0x5 followed by a read returns 0x5.
